// File: rtl/acq_capture_ctrl.sv
// acq_capture_ctrl: decimates the ADC conversion strobe, captures a fixed
// number of samples per run and writes them to the FIFO one channel at a time.
module acq_capture_ctrl #(
    parameter int  CH_NUM = 2,
    parameter int  DATA_W = 12,
    parameter int  DIV_W  = 11,
    parameter int  CNT_W  = 11,
    localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Start,
    input  logic                     Stop,
    input  logic                     Mode,
    input  logic [DIV_W-1:0]         Sample_Div,
    input  logic [CNT_W-1:0]         Num_Samples,
    input  logic                     ADC_Conv_Done,
    input  logic [CH_NUM*DATA_W-1:0] ADC_Data,
    input  logic                     FIFO_Full,
    output logic                     Wr_En,
    output logic [DATA_W-1:0]        Wr_Data,
    output logic [CH_W-1:0]          Wr_Ch,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_NUM - 1);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_overflow;
    logic                          r_mode;
    logic                          r_stop_pend;
    logic [DIV_W-1:0]              r_div;
    logic [DIV_W-1:0]              r_div_cnt;
    logic [CNT_W-1:0]              r_num;
    logic [CNT_W-1:0]              r_smp_cnt;
    logic [CH_NUM-1:0][DATA_W-1:0] r_hold;
    logic [CH_W-1:0]               r_ch_idx;

    logic w_accept;
    logic w_wr;
    logic w_last_wr;
    logic w_blk_done;
    logic w_stop_any;

    // A conversion is kept only when the divider count has reached the ratio.
    assign w_accept   = (r_state != ST_IDLE) && ADC_Conv_Done && (r_div_cnt == r_div);
    assign w_wr       = (r_state == ST_EMIT) && !FIFO_Full;
    assign w_last_wr  = w_wr && (r_ch_idx == LAST_CH);
    assign w_blk_done = w_last_wr && ((r_smp_cnt + CNT_W'(1)) == r_num);
    // A Stop arriving on the last-channel write still ends the run.
    assign w_stop_any = r_stop_pend || Stop;

    assign Wr_En    = w_wr;
    assign Wr_Data  = r_hold[r_ch_idx];
    assign Wr_Ch    = r_ch_idx;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Overflow = r_overflow;

    // State register; Busy is registered from the next state so it tracks the FSM.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state selection for the run / capture / emit sequence.
    always_comb begin
        // NOTE: default assigned first so no path leaves the next state unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start && (Num_Samples != '0)) begin
                    w_state_nxt = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (Stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_last_wr) begin
                    if (w_blk_done) begin
                        w_state_nxt = (r_mode && !w_stop_any) ? ST_ACQ : ST_IDLE;
                    end else if (w_stop_any) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACQ;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Configuration, counters, hold register and status flags.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mode      <= 1'b0;
            r_div       <= '0;
            r_num       <= '0;
            r_div_cnt   <= '0;
            r_smp_cnt   <= '0;
            // NOTE: the hold register is reset so Wr_Data reads 0 out of reset.
            r_hold      <= '0;
            r_ch_idx    <= '0;
            r_stop_pend <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (Start) begin
                    r_mode      <= Mode;
                    r_div       <= Sample_Div;
                    r_num       <= Num_Samples;
                    r_div_cnt   <= '0;
                    r_smp_cnt   <= '0;
                    r_ch_idx    <= '0;
                    r_stop_pend <= 1'b0;
                    r_overflow  <= 1'b0;
                    r_done      <= (Num_Samples == '0);
                end
            end else begin
                if (ADC_Conv_Done) begin
                    r_div_cnt <= (r_div_cnt == r_div) ? '0 : r_div_cnt + DIV_W'(1);
                end
                if ((r_state == ST_ACQ) && w_accept && !Stop) begin
                    r_hold   <= ADC_Data;
                    r_ch_idx <= '0;
                end
                if (r_state == ST_EMIT) begin
                    if (w_accept) begin
                        r_overflow <= 1'b1;
                    end
                    if (Stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_wr) begin
                        r_ch_idx <= (r_ch_idx == LAST_CH) ? '0 : r_ch_idx + CH_W'(1);
                    end
                    if (w_last_wr) begin
                        r_stop_pend <= 1'b0;
                        if (w_blk_done) begin
                            r_done    <= 1'b1;
                            r_smp_cnt <= r_mode ? '0 : r_smp_cnt + CNT_W'(1);
                        end else begin
                            r_smp_cnt <= r_smp_cnt + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// tb_acq_capture_ctrl: directed and random stimulus against a sample-level
// reference model; expected writes and per-cycle status go through queues.
module tb_acq_capture_ctrl;

    localparam int CH_NUM = 2;
    localparam int DATA_W = 12;
    localparam int DIV_W  = 11;
    localparam int CNT_W  = 11;
    localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int AW     = CH_NUM * DATA_W;

    logic              Clk           = 1'b0;
    logic              Rst_n         = 1'b0;
    logic              Start         = 1'b0;
    logic              Stop          = 1'b0;
    logic              Mode          = 1'b0;
    logic [DIV_W-1:0]  Sample_Div    = '0;
    logic [CNT_W-1:0]  Num_Samples   = '0;
    logic              ADC_Conv_Done = 1'b0;
    logic [AW-1:0]     ADC_Data      = '0;
    logic              FIFO_Full     = 1'b0;
    logic              Wr_En;
    logic [DATA_W-1:0] Wr_Data;
    logic [CH_W-1:0]   Wr_Ch;
    logic              Busy;
    logic              Done;
    logic              Overflow;

    acq_capture_ctrl #(
        .CH_NUM (CH_NUM),
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Start         (Start),
        .Stop          (Stop),
        .Mode          (Mode),
        .Sample_Div    (Sample_Div),
        .Num_Samples   (Num_Samples),
        .ADC_Conv_Done (ADC_Conv_Done),
        .ADC_Data      (ADC_Data),
        .FIFO_Full     (FIFO_Full),
        .Wr_En         (Wr_En),
        .Wr_Data       (Wr_Data),
        .Wr_Ch         (Wr_Ch),
        .Busy          (Busy),
        .Done          (Done),
        .Overflow      (Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              ovf;
        logic              wr;
        logic              chk;
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } st_t;

    st_t                      sq[$];
    logic [CH_W+DATA_W-1:0]   wq[$];

    int total  = 0;
    int bad    = 0;
    int n_wr   = 0;
    int n_done = 0;
    int w0     = 0;
    int d0     = 0;

    // Reference model: a run either waits for an accepted conversion or has
    // m_pend channel writes of the captured sample still outstanding.
    bit                m_run;
    bit                m_done;
    bit                m_ovf;
    bit                m_stop;
    bit                m_mode;
    int                m_div;
    int                m_divc;
    int                m_num;
    int                m_smp;
    int                m_pend;
    logic [DATA_W-1:0] m_cur [CH_NUM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_done = 0;
        m_ovf  = 0;
        m_stop = 0;
        m_mode = 0;
        m_div  = 0;
        m_divc = 0;
        m_num  = 0;
        m_smp  = 0;
        m_pend = 0;
        for (int i = 0; i < CH_NUM; i++) m_cur[i] = '0;
        sq.delete();
        wq.delete();
    endtask

    // Predict this cycle's outputs from the current inputs, then advance one clock.
    task automatic model_eval();
        st_t e;
        bit  nd;
        bit  acc;
        bit  wr;
        nd = 0;
        acc = 0;
        wr = m_run && (m_pend > 0) && !FIFO_Full;
        e.busy = m_run;
        e.done = m_done;
        e.ovf  = m_ovf;
        e.wr   = wr;
        e.chk  = m_run && (m_pend > 0);
        e.ch   = (m_pend > 0) ? CH_W'(CH_NUM - m_pend) : '0;
        e.data = (m_pend > 0) ? m_cur[CH_NUM - m_pend] : '0;
        sq.push_back(e);
        if (wr) wq.push_back({e.ch, e.data});
        if (!m_run) begin
            if (Start) begin
                m_mode = Mode;
                m_div  = int'(Sample_Div);
                m_num  = int'(Num_Samples);
                m_divc = 0;
                m_smp  = 0;
                m_ovf  = 0;
                m_stop = 0;
                if (m_num == 0) nd = 1;
                else m_run = 1;
            end
        end else begin
            if (ADC_Conv_Done) begin
                if (m_divc == m_div) begin
                    acc = 1;
                    m_divc = 0;
                end else begin
                    m_divc++;
                end
            end
            if (m_pend == 0) begin
                if (Stop) begin
                    m_run = 0;
                end else if (acc) begin
                    for (int i = 0; i < CH_NUM; i++) m_cur[i] = ADC_Data[i*DATA_W +: DATA_W];
                    m_pend = CH_NUM;
                end
            end else begin
                if (acc) m_ovf = 1;
                if (Stop) m_stop = 1;
                if (wr) begin
                    m_pend--;
                    if (m_pend == 0) begin
                        m_smp++;
                        if (m_smp == m_num) begin
                            nd = 1;
                            if (m_mode && !m_stop) m_smp = 0;
                            else m_run = 0;
                        end else if (m_stop) begin
                            m_run = 0;
                        end
                        m_stop = 0;
                    end
                end
            end
        end
        m_done = nd;
    endtask

    task automatic step();
        model_eval();
        @(posedge Clk);
        #1;
        Start         = 1'b0;
        Stop          = 1'b0;
        ADC_Conv_Done = 1'b0;
        ADC_Data      = AW'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic conv_step();
        ADC_Conv_Done = 1'b1;
        step();
    endtask

    task automatic start_run(input logic mode, input int div, input int num);
        Mode        = mode;
        Sample_Div  = DIV_W'(div);
        Num_Samples = CNT_W'(num);
        Start       = 1'b1;
        step();
    endtask

    st_t                    mon_e;
    logic [CH_W+DATA_W-1:0] mon_w;

    // Monitor: sample outputs mid-cycle and compare with the queued expectations.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Wr_En) n_wr++;
            if (Done) n_done++;
            if (sq.size() > 0) begin
                mon_e = sq.pop_front();
                check("busy", 64'(Busy), 64'(mon_e.busy));
                check("done", 64'(Done), 64'(mon_e.done));
                check("overflow", 64'(Overflow), 64'(mon_e.ovf));
                check("wr_en", 64'(Wr_En), 64'(mon_e.wr));
                if (mon_e.chk) begin
                    check("wr_ch", 64'(Wr_Ch), 64'(mon_e.ch));
                    check("wr_data", 64'(Wr_Data), 64'(mon_e.data));
                end
            end
            if (Wr_En) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: ch=%0d data=%0h at %0t", Wr_Ch, Wr_Data, $time);
                end else begin
                    mon_w = wq.pop_front();
                    check("write", 64'({Wr_Ch, Wr_Data}), 64'(mon_w));
                end
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check("rst_wr_en", 64'(Wr_En), 64'd0);
        check("rst_wr_data", 64'(Wr_Data), 64'd0);
        check("rst_wr_ch", 64'(Wr_Ch), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_overflow", 64'(Overflow), 64'd0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // One-shot, keep 1 of 4, four samples.
        w0 = n_wr; d0 = n_done;
        start_run(1'b0, 3, 4);
        for (int k = 0; k < 16; k++) begin
            conv_step();
            idle(3);
        end
        idle(6);
        check("p1_writes", 64'(n_wr - w0), 64'd8);
        check("p1_dones", 64'(n_done - d0), 64'd1);
        check("p1_busy_end", 64'(Busy), 64'd0);

        // Continuous, every conversion, blocks of three, Stop during the 7th sample.
        w0 = n_wr; d0 = n_done;
        start_run(1'b1, 0, 3);
        idle(1);
        for (int k = 1; k <= 7; k++) begin
            conv_step();
            if (k == 7) Stop = 1'b1;
            step();
            idle(2);
        end
        idle(4);
        check("p2_writes", 64'(n_wr - w0), 64'd14);
        check("p2_dones", 64'(n_done - d0), 64'd2);
        check("p2_busy_end", 64'(Busy), 64'd0);

        // FIFO backpressure for five cycles mid-sample.
        w0 = n_wr; d0 = n_done;
        start_run(1'b0, 0, 1);
        idle(1);
        conv_step();
        FIFO_Full = 1'b1;
        idle(5);
        FIFO_Full = 1'b0;
        idle(5);
        check("p3_writes", 64'(n_wr - w0), 64'd2);
        check("p3_dones", 64'(n_done - d0), 64'd1);

        // Conversion every cycle: samples arriving during emission are dropped.
        w0 = n_wr; d0 = n_done;
        start_run(1'b0, 0, 3);
        repeat (12) conv_step();
        idle(4);
        check("p4_writes", 64'(n_wr - w0), 64'd6);
        check("p4_ovf_sticky", 64'(Overflow), 64'd1);
        idle(3);
        check("p4_ovf_idle", 64'(Overflow), 64'd1);

        // Zero-length block: single Done, never busy, Overflow cleared.
        d0 = n_done;
        start_run(1'b0, 0, 0);
        idle(3);
        check("p5_zero_done", 64'(n_done - d0), 64'd1);
        check("p5_zero_busy", 64'(Busy), 64'd0);
        check("p5_ovf_clear", 64'(Overflow), 64'd0);

        // Start while busy must not change the running configuration.
        w0 = n_wr; d0 = n_done;
        start_run(1'b0, 1, 3);
        idle(2);
        Mode = 1'b1; Sample_Div = '0; Num_Samples = CNT_W'(1); Start = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            conv_step();
            idle(3);
        end
        idle(4);
        check("p5_writes", 64'(n_wr - w0), 64'd6);
        check("p5_dones", 64'(n_done - d0), 64'd1);

        // Reset asserted while a sample is being written.
        start_run(1'b1, 0, 5);
        idle(1);
        ADC_Data = AW'(24'hABC_DEF);
        conv_step();
        check("p6_in_emit", 64'(Wr_En), 64'd1);
        Rst_n = 1'b0;
        model_reset();
        #1;
        check("p6_rst_wr_en", 64'(Wr_En), 64'd0);
        check("p6_rst_wr_data", 64'(Wr_Data), 64'd0);
        check("p6_rst_wr_ch", 64'(Wr_Ch), 64'd0);
        check("p6_rst_busy", 64'(Busy), 64'd0);
        check("p6_rst_done", 64'(Done), 64'd0);
        check("p6_rst_overflow", 64'(Overflow), 64'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        w0 = n_wr;
        for (int k = 0; k < 8; k++) begin
            conv_step();
            idle(1);
        end
        check("p6_no_write_after_rst", 64'(n_wr - w0), 64'd0);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                Start       = 1'b1;
                Mode        = 1'($urandom_range(0, 1));
                Sample_Div  = DIV_W'($urandom_range(0, 3));
                Num_Samples = CNT_W'($urandom_range(0, 4));
            end
            Stop          = ($urandom_range(0, 39) == 0);
            ADC_Conv_Done = ($urandom_range(0, 2) == 0);
            FIFO_Full     = ($urandom_range(0, 3) == 0);
            step();
        end
        FIFO_Full = 1'b0;
        idle(20);
        check("write_queue_drained", 64'(wq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
